// File: rtl/popcount_arbiter.sv
// Round-robin arbiter in front of a sliced popcount engine: one 32-bit word is
// accepted at a time, counted SLICE_W bits per cycle, and returned with its owner id.
module popcount_arbiter #(
  parameter int  NUM_REQ = 4,
  parameter int  SLICE_W = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 counter_reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [5:0]           rsp_count,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  localparam int NSLICE   = 32 / SLICE_W;
  localparam int SLICE_IW = $clog2(NSLICE);

  typedef enum logic [1:0] {IDLE, COUNT, RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]         data_q, data_d;
  logic [5:0]          acc_q, acc_d;
  logic [SLICE_IW-1:0] slice_q, slice_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [5:0]          rsp_count_q, rsp_count_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

  logic                grant_any;
  logic [ID_W-1:0]     grant_idx;
  logic                accept;
  logic [SLICE_W-1:0]  slice_bits;
  logic [5:0]          acc_sum;

  function automatic logic [5:0] pop_slice(input logic [SLICE_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int b = 0; b < SLICE_W; b++) c = c + 6'(v[b]);
    return c;
  endfunction

  // First valid requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!grant_any && req_valid[(int'(rr_ptr_q) + off) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr_q) + off) % NUM_REQ);
      end
    end
  end

  assign accept     = (state_q == IDLE) && grant_any && !counter_reset;
  assign req_ready  = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid  = (state_q == RESP) && !counter_reset;
  assign busy       = (state_q != IDLE) && !counter_reset;
  assign rsp_count  = rsp_count_q;
  assign rsp_id     = rsp_id_q;

  assign slice_bits = data_q[int'(slice_q) * SLICE_W +: SLICE_W];
  assign acc_sum    = acc_q + pop_slice(slice_bits);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    data_d      = data_q;
    acc_d       = acc_q;
    slice_d     = slice_q;
    owner_d     = owner_q;
    rsp_count_d = rsp_count_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d   = req_data[int'(grant_idx) * 32 +: 32];
          owner_d  = grant_idx;
          acc_d    = '0;
          slice_d  = '0;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d  = COUNT;
        end
      end
      COUNT: begin
        acc_d   = acc_sum;
        slice_d = slice_q + SLICE_IW'(1);
        // Results are published only on entry to RESP so they stay put while counting.
        if (slice_q == SLICE_IW'(NSLICE - 1)) begin
          rsp_count_d = acc_sum;
          rsp_id_d    = owner_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (counter_reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      data_q      <= '0;
      acc_q       <= '0;
      slice_q     <= '0;
      owner_q     <= '0;
      rsp_count_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      slice_q     <= slice_d;
      owner_q     <= owner_d;
      rsp_count_q <= rsp_count_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

endmodule
